// File: rtl/n1_pbus_mem_tgt.sv
// n1_pbus_mem_tgt: pipelined Wishbone program-memory target with fixed response latency and stall
module n1_pbus_mem_tgt #(
  parameter int ADR_WIDTH = 14,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 1,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk_i,
  input  logic                 sync_rst_i,
  input  logic                 pbus_cyc_i,
  input  logic                 pbus_stb_i,
  input  logic                 pbus_we_i,
  input  logic [ADR_WIDTH-1:0] pbus_adr_i,
  input  logic [15:0]          pbus_dat_i,
  output logic                 pbus_ack_o,
  output logic                 pbus_err_o,
  output logic                 pbus_stall_o,
  output logic [15:0]          pbus_dat_o,
  output logic [2:0]           prb_tgt_cnt_o
);
  localparam int LP1 = LATENCY + 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [15:0] mem_q [DEPTH];
  logic [LATENCY:0] vld_q, vld_d;
  logic err_q [LP1];
  logic [15:0] dat_q [LP1];
  logic [2:0] cnt_q, cnt_d;
  logic rsp, acc, in_rng;
  logic [AW-1:0] idx;
  always_comb begin
    in_rng = 32'(pbus_adr_i) < $unsigned(DEPTH);
    idx = pbus_adr_i[AW-1:0];
    rsp = vld_q[LATENCY] & pbus_cyc_i;
    pbus_stall_o = pbus_cyc_i & (cnt_q == 3'(MAX_OUT)) & ~rsp;
    acc = pbus_cyc_i & pbus_stb_i & ~pbus_stall_o;
    pbus_ack_o = rsp & ~err_q[LATENCY];
    pbus_err_o = rsp & err_q[LATENCY];
    pbus_dat_o = pbus_ack_o ? dat_q[LATENCY] : '0;
    vld_d = pbus_cyc_i ? (vld_q << 1) | LP1'(acc) : '0;
    cnt_d = pbus_cyc_i ? cnt_q + 3'(acc) - 3'(rsp) : '0;
    prb_tgt_cnt_o = cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    err_q[0] <= ~in_rng;
    dat_q[0] <= (pbus_we_i | ~in_rng) ? '0 : mem_q[idx];
    for (int i = 1; i < LP1; i++) begin
      err_q[i] <= err_q[i-1];
      dat_q[i] <= dat_q[i-1];
    end
    if (acc & pbus_we_i & in_rng & ~sync_rst_i) mem_q[idx] <= pbus_dat_i;
  end
  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      assert (!(pbus_ack_o && pbus_err_o));
      assert (!rsp || cnt_q != 3'd0);
      assert (cnt_q <= 3'(MAX_OUT));
    end
  end
endmodule

// File: tb/tb_n1_pbus_mem_tgt.sv
// tb_n1_pbus_mem_tgt: directed bench with a queue-based response model for two latency configurations
module tb_n1_pbus_mem_tgt;
  typedef struct {int due; logic err; logic [15:0] d;} rsp_t;
  logic clk = 0;
  logic rst, cyc, stb, we;
  logic [13:0] adr;
  logic [15:0] wdat;
  logic ack [2], err [2], stall [2];
  logic [15:0] rdat [2];
  logic [2:0] cnt [2];
  int total = 0, bad = 0, cyc_n = 0;
  bit chk_en = 0;
  rsp_t mq [2][$];
  logic [15:0] mm [2][1024];
  logic e_rsp [2] = '{0, 0};
  logic e_acc [2] = '{0, 0};
  n1_pbus_mem_tgt u0 (
    .clk_i(clk), .sync_rst_i(rst), .pbus_cyc_i(cyc), .pbus_stb_i(stb), .pbus_we_i(we),
    .pbus_adr_i(adr), .pbus_dat_i(wdat), .pbus_ack_o(ack[0]), .pbus_err_o(err[0]),
    .pbus_stall_o(stall[0]), .pbus_dat_o(rdat[0]), .prb_tgt_cnt_o(cnt[0])
  );
  n1_pbus_mem_tgt #(.LATENCY(2), .MAX_OUT(2)) u1 (
    .clk_i(clk), .sync_rst_i(rst), .pbus_cyc_i(cyc), .pbus_stb_i(stb), .pbus_we_i(we),
    .pbus_adr_i(adr), .pbus_dat_i(wdat), .pbus_ack_o(ack[1]), .pbus_err_o(err[1]),
    .pbus_stall_o(stall[1]), .pbus_dat_o(rdat[1]), .prb_tgt_cnt_o(cnt[1])
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, int k, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s u%0d act=%h exp=%h cycle=%0d", nm, k, a, e, cyc_n);
    end
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rsp_t f;
      int sz;
      logic st;
      sz = mq[k].size();
      f = '{-1, 1'b0, 16'h0};
      if (sz > 0) f = mq[k][0];
      e_rsp[k] = cyc && sz > 0 && f.due == cyc_n;
      st = cyc && sz == 2 && !e_rsp[k];
      e_acc[k] = cyc && stb && !st && !rst;
      if (chk_en) begin
        chk("m_ack", k, 32'(ack[k]), 32'(e_rsp[k] && !f.err));
        chk("m_err", k, 32'(err[k]), 32'(e_rsp[k] && f.err));
        chk("m_dat", k, 32'(rdat[k]), (e_rsp[k] && !f.err) ? 32'(f.d) : 32'd0);
        chk("m_stall", k, 32'(stall[k]), 32'(st));
        chk("m_cnt", k, 32'(cnt[k]), 32'(sz));
      end
    end
  end
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || !cyc) mq[k].delete();
      else begin
        if (e_rsp[k]) void'(mq[k].pop_front());
        if (e_acc[k]) begin
          logic inr;
          inr = adr < 14'd1024;
          mq[k].push_back('{cyc_n + (k ? 3 : 2), !inr, (we || !inr) ? 16'h0 : mm[k][adr[9:0]]});
          if (we && inr) mm[k][adr[9:0]] = wdat;
        end
      end
    end
    cyc_n++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic single(input logic w, input logic [13:0] a, input logic [15:0] d,
                        input logic ea, input logic ee, input logic [15:0] ed, input string nm);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    tick();
    stb = 0; we = 0;
    @(negedge clk);
    chk({nm, "_early"}, 0, 32'(ack[0] | err[0]), 0);
    tick();
    @(negedge clk);
    chk({nm, "_ack"}, 0, 32'(ack[0]), 32'(ea));
    chk({nm, "_err"}, 0, 32'(err[0]), 32'(ee));
    chk({nm, "_dat"}, 0, 32'(rdat[0]), 32'(ed));
    tick();
    @(negedge clk);
    chk({nm, "_late"}, 0, 32'(ack[0] | err[0]), 0);
    repeat (2) tick();
    cyc = 0;
    tick();
  endtask
  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0;
    repeat (2) tick();
    chk("rst_ack", 0, 32'(ack[0]), 0);
    chk("rst_err", 0, 32'(err[0]), 0);
    chk("rst_stall", 0, 32'(stall[0]), 0);
    chk("rst_cnt", 0, 32'(cnt[0]), 0);
    chk("rst_dat", 0, 32'(rdat[0]), 0);
    rst = 0;
    chk_en = 1;
    for (int i = 0; i < 4; i++) single(1, 14'(i), 16'hA000 + 16'(i), 1, 0, 0, "pre_wr");
    single(1, 5, 16'hBEEF, 1, 0, 0, "wr5");
    single(1, 976, 16'h5A5A, 1, 0, 0, "wr976");
    single(1, 6, 16'h1111, 1, 0, 0, "wr6");
    single(0, 5, 0, 1, 0, 16'hBEEF, "rd5");
    cyc = 1; stb = 1; we = 0;
    for (int i = 0; i < 4; i++) begin
      adr = 14'(i);
      @(negedge clk);
      chk("burst_stall", 0, 32'(stall[0]), 0);
      if (i == 2) chk("burst_stall_l2", 1, 32'(stall[1]), 1);
      if (i >= 2) begin
        chk("burst_ack", 0, 32'(ack[0]), 1);
        chk("burst_dat", 0, 32'(rdat[0]), 32'(16'hA000 + 16'(i - 2)));
      end
      tick();
    end
    stb = 0;
    for (int j = 2; j < 4; j++) begin
      @(negedge clk);
      chk("burst_tail_dat", 0, 32'(rdat[0]), 32'(16'hA000 + 16'(j)));
      tick();
    end
    repeat (2) tick();
    cyc = 0;
    tick();
    single(1, 7, 16'h1234, 1, 0, 0, "wr7");
    single(0, 7, 0, 1, 0, 16'h1234, "rd7");
    single(0, 1024, 0, 0, 1, 0, "oor_rd");
    single(1, 2000, 16'hDEAD, 0, 1, 0, "oor_wr");
    single(0, 976, 0, 1, 0, 16'h5A5A, "alias");
    cyc = 1; stb = 1; adr = 0;
    tick();
    adr = 1;
    tick();
    cyc = 0; stb = 0;
    @(negedge clk);
    chk("abort_ack", 0, 32'(ack[0] | err[0]), 0);
    tick();
    @(negedge clk);
    chk("abort_cnt", 0, 32'(cnt[0]), 0);
    chk("abort_stall", 0, 32'(stall[0]), 0);
    chk("abort_ack2", 0, 32'(ack[0] | err[0]), 0);
    tick();
    cyc = 1; stb = 1; adr = 1;
    tick();
    adr = 2;
    tick();
    stb = 0; rst = 1;
    @(negedge clk);
    chk("mid_cnt", 0, 32'(cnt[0]), 2);
    tick();
    rst = 0;
    @(negedge clk);
    chk("mrst_ack", 0, 32'(ack[0] | err[0]), 0);
    chk("mrst_stall", 0, 32'(stall[0]), 0);
    chk("mrst_cnt", 0, 32'(cnt[0]), 0);
    chk("mrst_cnt_l2", 1, 32'(cnt[1]), 0);
    tick();
    @(negedge clk);
    chk("mrst_late", 0, 32'(ack[0] | err[0]), 0);
    tick();
    cyc = 0;
    tick();
    cyc = 1; stb = 1; we = 1; adr = 6; wdat = 16'h7777; rst = 1;
    tick();
    rst = 0; stb = 0; we = 0;
    repeat (3) tick();
    cyc = 0;
    tick();
    single(0, 6, 0, 1, 0, 16'h1111, "rst_wr");
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/n1_pbus_mem_tgt.md
Name: n1_pbus_mem_tgt

Overview:
Pipelined Wishbone target that models N1 program memory on the pbus. It responds to the flow-control initiator's pbus_cyc/stb requests with ack or err after a configurable, fixed latency. It applies stall back-pressure when too many requests are outstanding. It serves as the simulation and formal counterpart of the N1 program bus initiator and as a synthesizable on-chip program RAM.

Parameters:
ADR_WIDTH, 14, pbus word-address width
DEPTH, 1024, implemented words; addresses >= DEPTH are out of range
LATENCY, 1, wait states between acceptance and response (0..3); response arrives LATENCY+1 cycles after acceptance
MAX_OUT, 2, maximum outstanding requests (1..LATENCY+1)

Ports:
clk_i  in  1  module clock
sync_rst_i  in  1  synchronous reset, active high
pbus_cyc_i  in  1  bus cycle indicator
pbus_stb_i  in  1  access request
pbus_we_i  in  1  write enable
pbus_adr_i  in  ADR_WIDTH  word address
pbus_dat_i  in  16  write data
pbus_ack_o  out  1  bus acknowledge
pbus_err_o  out  1  error indicator (out-of-range address)
pbus_stall_o  out  1  access delay
pbus_dat_o  out  16  read data, valid with ack
prb_tgt_cnt_o  out  3  probe: outstanding request count

Behaviour:
- Single clock, clk_i. Reset is synchronous and active-high (sync_rst_i); there is no asynchronous reset.
- Reset: ack=0, err=0, stall=0, dat_o=0, count=0, all pipeline stages invalid. Memory contents are not reset.
- Accept: accept = cyc_i & stb_i & ~stall_o. Each accepted request yields exactly one response cycle (ack XOR err), in request order.
- Response pipeline: LATENCY+1 stages, each holding {valid, err, data}. Stage 0 loads on accept; stages shift every cycle; the last stage drives the outputs.
  - ack_o = last.valid & ~last.err
  - err_o = last.valid & last.err
  - dat_o = last.data when ack_o, else 0
- Reads: data is sampled from memory at acceptance (the synchronous read result is placed in stage 0).
- Writes: commit to memory in the acceptance cycle when adr < DEPTH. The ack carries dat_o=0.
- Out of range: when adr >= DEPTH, no memory write occurs and the response is err with dat_o=0.
- Outstanding count:
  - +1 on accept, -1 on a response cycle; both in the same cycle leaves it unchanged.
  - Range is 0..MAX_OUT.
  - The count equals the number of valid pipeline stages.
- Stall: stall_o = (count == MAX_OUT) & ~(response this cycle). It is combinational from registered state, so a retiring response frees a slot in the same cycle. stall_o=0 whenever cyc_i=0.
- stb_i without cyc_i is ignored.
- Abort: when cyc_i=0, all pipeline valid bits clear on the next edge and count goes to 0. Responses already registered for that edge are suppressed, so no ack/err appears after the cycle drops. Writes already accepted stay committed.
- Simultaneous sync_rst_i and accept: reset wins; no write, no response.
- Probe: prb_tgt_cnt_o = count, zero-extended.
- Asserts for the formal bench:
  - ack_o & err_o never both high.
  - No ack/err without a prior accept.
  - count <= MAX_OUT.

Test Plan:
1. Single read, LATENCY=1: preload mem[5]=16'hBEEF, pulse cyc/stb with adr=5 at cycle t → ack=1 and dat_o=BEEF at t+2, then ack=0.
2. Back-to-back reads, MAX_OUT=2: stb held for 4 requests on adr 0..3 → stall=1 on the third request until the first ack, then acks arrive in order with no gaps once steady, carrying mem[0..3] in order.
3. Write then read: write 16'h1234 to adr 7 (ack at t+2, dat_o=0), then read adr 7 → dat_o=1234.
4. Out of range, DEPTH=1024: read adr 1024 → err=1, ack=0, dat_o=0 after 2 cycles; write to adr 2000 → err, and mem[2000 mod 1024] is unchanged.
5. Abort: accept 2 reads, drop cyc the next cycle → no ack/err, count=0, stall=0.
6. Reset mid-operation: assert sync_rst_i with 2 outstanding requests → next cycle ack=err=stall=0, count=0, and later responses never appear.
